equiv_stim_sequencer: RTL
=========================

// Module: equiv_stim_sequencer
// PURPOSE
//  Drives the shared input vector of an equivalence harness (two DUT copies fed from one
//  stimulus bus) and checks their outputs. On start: issues NUM_VECTORS pseudo-random vectors,
//  one per clk. Compares y_1/y_2 after a fixed DUT latency, counts mismatches, captures the first failure.
//  Sits beside the two DUT instances and replaces the free-running bench stimulus plus bare assert.
// PARAMETERS
//  IN_W        33               stimulus width (concatenated DUT inputs), >=2
//  OUT_W       91               DUT output width compared
//  TAPS        33'h1_0008_0000  Galois right-shift LFSR feedback mask (x^33+x^20+1)
//  SEED        33'h1            LFSR load value; a value of 0 is replaced by 1
//  NUM_VECTORS 1024             vectors per run, 1..65535
//  LAT         0                DUT latency in clk cycles, 0..15
// PORTS
//  clk             in   1      single clock, rising edge
//  rst_n           in   1      asynchronous active-low reset
//  start           in   1      begin run; sampled in IDLE only
//  abort           in   1      synchronous abort; wins over start
//  stim            out  IN_W   vector to both DUT copies
//  y_1             in   OUT_W  output of DUT copy 1
//  y_2             in   OUT_W  output of DUT copy 2
//  busy            out  1      high in RUN and DRAIN
//  done            out  1      one-cycle pulse at end of a completed run
//  pass            out  1      mismatch_count==0 at done; held until next start
//  mismatch_count  out  16     saturating at 16'hFFFF
//  fail_valid      out  1      a first failure has been captured
//  fail_idx        out  16     vector index of first failure
//  fail_y1         out  OUT_W  y_1 at first failure
//  fail_y2         out  OUT_W  y_2 at first failure
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE; every output 0; LFSR=0; delay line cleared.
//  - FSM IDLE->RUN->DRAIN->DONE->IDLE.
//    IDLE: start&!abort -> load LFSR=SEED, vec_idx=0, clear count/fail_*/pass -> RUN.
//    RUN: stim=LFSR; each cycle push {valid=1, vec_idx} into the delay line; advance LFSR; vec_idx++.
//      After vector NUM_VECTORS-1 has been issued: -> DRAIN if LAT>0, else -> DONE.
//    DRAIN: exactly LAT cycles; stim holds last vector; pushes valid=0.
//    DONE: done=1 for 1 cycle, pass=(count==0); -> IDLE.
//  - LFSR next = {1'b0,s[IN_W-1:1]} ^ (s[0] ? TAPS : 0).
//  - stim holds its last value outside RUN; it is 0 only after reset.
//  - Compare point: the delay line is LAT deep; for LAT=0 it is bypassed and the tag is taken the same cycle.
//    Where the tag is valid and y_1!=y_2: count++ (sat). If !fail_valid: capture idx, y_1, y_2, set fail_valid.
//    If the tag is invalid, no compare takes place.
//  - Latency: start sampled at edge E0; done high after edge E0+NUM_VECTORS+LAT.
//  - start while busy or in DONE: ignored.
//  - abort in RUN/DRAIN/DONE: -> IDLE next edge; no done pulse; delay line cleared.
//    Count and fail_* keep their values; pass=0.
//  - rst_n low mid-run: immediate return to reset values; a new start is required after release.
// TESTING
//  1. NUM_VECTORS=16, LAT=0, y_2=y_1 -> done after E0+16, pass=1, count=0, fail_valid=0.
//  2. SEED=1 -> stim sequence 33'h1, 33'h1_0008_0000, 33'h0_8004_0000.
//  3. LAT=0, bench flips y_2[0] on vector 5 only -> count=1, fail_idx=5, fail_y1^fail_y2=1, pass=0.
//  4. LAT=2 registered DUTs, faults on vectors 3 and 9 -> count=2, fail_idx=3; done after E0+18.
//  5. abort asserted in the 7th RUN cycle -> IDLE next edge, busy=0, no done; a new start then completes normally.
//  6. rst_n pulsed low mid-RUN -> stim=0, busy=0, count=0 asynchronously; start during reset ignored.

Source files
------------

// File: rtl/equiv_stim_sequencer_if.sv
// Bus between the equivalence sequencer and its controller/DUT side:
// run control, the shared stimulus vector, both DUT outputs and the
// result/status signals.
interface equiv_stim_sequencer_if #(
  parameter int IN_W  = 33,
  parameter int OUT_W = 91
);
  logic             start;
  logic             abort;
  logic [IN_W-1:0]  stim;
  logic [OUT_W-1:0] y_1;
  logic [OUT_W-1:0] y_2;
  logic             busy;
  logic             done;
  logic             pass;
  logic [15:0]      mismatch_count;
  logic             fail_valid;
  logic [15:0]      fail_idx;
  logic [OUT_W-1:0] fail_y1;
  logic [OUT_W-1:0] fail_y2;

  // Controller / harness side: drives control and DUT outputs, observes results.
  modport master (
    output start, abort, y_1, y_2,
    input  stim, busy, done, pass, mismatch_count,
    input  fail_valid, fail_idx, fail_y1, fail_y2
  );

  // Sequencer side.
  modport slave (
    input  start, abort, y_1, y_2,
    output stim, busy, done, pass, mismatch_count,
    output fail_valid, fail_idx, fail_y1, fail_y2
  );
endinterface

// File: rtl/equiv_stim_sequencer.sv
// Equivalence-harness sequencer: issues NUM_VECTORS LFSR vectors to two DUT
// copies, compares their outputs LAT cycles later, counts mismatches and
// captures the first failing vector index and outputs.
module equiv_stim_sequencer #(
  parameter int              IN_W        = 33,
  parameter int              OUT_W       = 91,
  parameter logic [IN_W-1:0] TAPS        = 33'h1_0008_0000,
  parameter logic [IN_W-1:0] SEED        = 33'h1,
  parameter int              NUM_VECTORS = 1024,
  parameter int              LAT         = 0
) (
  input logic                  clk,
  input logic                  rst_n,
  equiv_stim_sequencer_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [IN_W-1:0] SEED_EFF   = (SEED == '0) ? {{(IN_W-1){1'b0}}, 1'b1} : SEED;
  localparam logic [15:0]     LAST_IDX   = 16'(NUM_VECTORS - 1);
  localparam logic [3:0]      LAST_DRAIN = 4'((LAT > 0) ? (LAT - 1) : 0);

  function automatic logic [IN_W-1:0] lfsr_next(input logic [IN_W-1:0] s);
    return {1'b0, s[IN_W-1:1]} ^ (s[0] ? TAPS : {IN_W{1'b0}});
  endfunction

  state_t           r_state, w_state_nxt;
  logic [IN_W-1:0]  r_lfsr;
  logic [15:0]      r_idx;
  logic [3:0]       r_drain;
  logic             r_busy, r_done, r_pass;
  logic [15:0]      r_cnt, w_cnt_nxt;
  logic             r_fail_valid;
  logic [15:0]      r_fail_idx;
  logic [OUT_W-1:0] r_fail_y1, r_fail_y2;
  logic             w_start, w_abort, w_last, w_push_vld;
  logic             w_tag_vld, w_cmp;
  logic [15:0]      w_tag_idx;

  assign w_start    = (r_state == S_IDLE) && bus.start && !bus.abort;
  assign w_abort    = (r_state != S_IDLE) && bus.abort;
  assign w_last     = (r_state == S_RUN) && (r_idx == LAST_IDX);
  assign w_push_vld = (r_state == S_RUN) && !w_abort;

  // Next-state logic; abort wins over every other transition.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_nxt = S_RUN;
               else         w_state_nxt = S_IDLE;
      S_RUN:   if (w_abort)     w_state_nxt = S_IDLE;
               else if (w_last) w_state_nxt = (LAT > 0) ? S_DRAIN : S_DONE;
               else             w_state_nxt = S_RUN;
      S_DRAIN: if (w_abort)                    w_state_nxt = S_IDLE;
               else if (r_drain == LAST_DRAIN) w_state_nxt = S_DONE;
               else                            w_state_nxt = S_DRAIN;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register, LFSR/vector index (held on the last vector so stim keeps it), drain counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_lfsr  <= '0;
      r_idx   <= 16'd0;
      r_drain <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_lfsr <= SEED_EFF;
        r_idx  <= 16'd0;
      end else if (w_push_vld && !w_last) begin
        r_lfsr <= lfsr_next(r_lfsr);
        r_idx  <= r_idx + 16'd1;
      end else begin
        r_lfsr <= r_lfsr;
        r_idx  <= r_idx;
      end
      if (r_state == S_DRAIN) r_drain <= r_drain + 4'd1;
      else                    r_drain <= 4'd0;
    end
  end

  // Tag delay line aligning each vector index with its DUT output; bypassed when LAT is 0.
  if (LAT == 0) begin : g_bypass
    assign w_tag_vld = w_push_vld;
    assign w_tag_idx = r_idx;
  end else begin : g_dly
    logic        r_dly_vld [LAT];
    logic [15:0] r_dly_idx [LAT];

    // Shift tags one stage per cycle; abort flushes every stage.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < LAT; i++) begin
          r_dly_vld[i] <= 1'b0;
          r_dly_idx[i] <= 16'd0;
        end
      end else if (w_abort) begin
        for (int i = 0; i < LAT; i++) begin
          r_dly_vld[i] <= 1'b0;
          r_dly_idx[i] <= 16'd0;
        end
      end else begin
        r_dly_vld[0] <= w_push_vld;
        r_dly_idx[0] <= r_idx;
        for (int i = 1; i < LAT; i++) begin
          r_dly_vld[i] <= r_dly_vld[i-1];
          r_dly_idx[i] <= r_dly_idx[i-1];
        end
      end
    end

    assign w_tag_vld = r_dly_vld[LAT-1];
    assign w_tag_idx = r_dly_idx[LAT-1];
  end

  // Compare point and saturating mismatch count.
  always_comb begin
    w_cmp     = w_tag_vld && !w_abort && (bus.y_1 != bus.y_2);
    w_cnt_nxt = r_cnt;
    if (w_cmp && (r_cnt != 16'hFFFF)) w_cnt_nxt = r_cnt + 16'd1;
    else                              w_cnt_nxt = r_cnt;
  end

  // Mismatch count and first-failure capture; cleared only by a new start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= 16'd0;
      r_fail_valid <= 1'b0;
      r_fail_idx   <= 16'd0;
      r_fail_y1    <= '0;
      r_fail_y2    <= '0;
    end else if (w_start) begin
      r_cnt        <= 16'd0;
      r_fail_valid <= 1'b0;
      r_fail_idx   <= 16'd0;
      r_fail_y1    <= '0;
      r_fail_y2    <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
      if (w_cmp && !r_fail_valid) begin
        r_fail_valid <= 1'b1;
        r_fail_idx   <= w_tag_idx;
        r_fail_y1    <= bus.y_1;
        r_fail_y2    <= bus.y_2;
      end else begin
        r_fail_valid <= r_fail_valid;
      end
    end
  end

  // Registered status: busy/done follow the next state, pass is decided on entry to DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_pass <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt == S_RUN) || (w_state_nxt == S_DRAIN);
      r_done <= (w_state_nxt == S_DONE);
      if (w_start || w_abort)         r_pass <= 1'b0;
      else if (w_state_nxt == S_DONE) r_pass <= (w_cnt_nxt == 16'd0);
      else                            r_pass <= r_pass;
    end
  end

  assign bus.stim           = r_lfsr;
  assign bus.busy           = r_busy;
  assign bus.done           = r_done;
  assign bus.pass           = r_pass;
  assign bus.mismatch_count = r_cnt;
  assign bus.fail_valid     = r_fail_valid;
  assign bus.fail_idx       = r_fail_idx;
  assign bus.fail_y1        = r_fail_y1;
  assign bus.fail_y2        = r_fail_y2;

endmodule
